// File: rtl/word_downsizer_pkg.sv
// word_downsizer_pkg: shared widths and FSM state encoding for the word downsizer
package word_downsizer_pkg;
   localparam int WORD_W = 32;
   localparam int HALF_W = 16;
   typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_t;
endpackage

// File: rtl/word_downsizer.sv
// word_downsizer: splits 32-bit words into 16-bit half-words over valid/ready
// Optional macro WORD_DOWNSIZER_COMPRESS_EN: a word whose upper half is zero
// leaves as a single half-word flagged with o_out_ext.
module word_downsizer
   import word_downsizer_pkg::*;
#(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WORD_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [HALF_W-1:0] o_out_data,
   output logic              o_out_last,
   output logic              o_out_ext
);
   state_t            r_state;
   state_t            w_next;
   logic [WORD_W-1:0] r_wd;
   logic              r_cmp;
   logic              w_cmp;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic [HALF_W-1:0] w_first;
   logic [HALF_W-1:0] w_second;
`ifdef WORD_DOWNSIZER_COMPRESS_EN
   assign w_cmp     = (i_in_data[WORD_W-1:HALF_W] == '0);
   assign o_out_ext = o_out_valid && r_cmp;
`else
   assign w_cmp     = 1'b0;
   assign o_out_ext = 1'b0;
`endif
   assign o_in_ready  = !rst && (r_state == EMPTY || (r_state == SECOND && i_out_ready)
                                 || (r_state == FIRST && r_cmp && i_out_ready));
   assign o_out_valid = (r_state != EMPTY);
   assign w_in_xfer   = i_in_valid && o_in_ready;
   assign w_out_xfer  = o_out_valid && i_out_ready;
   // A compressed word always sends its low half, whatever the order
   assign w_first     = (LOW_FIRST || r_cmp) ? r_wd[HALF_W-1:0] : r_wd[WORD_W-1:HALF_W];
   assign w_second    = LOW_FIRST ? r_wd[WORD_W-1:HALF_W] : r_wd[HALF_W-1:0];
   assign o_out_data  = (r_state == FIRST) ? w_first : (r_state == SECOND) ? w_second : '0;
   assign o_out_last  = (r_state == SECOND) || (r_state == FIRST && r_cmp);
   // Next state: an accepted word always enters FIRST, even on the edge the previous one finishes
   always_comb begin
      w_next = r_state;
      if (r_state == EMPTY)
         w_next = w_in_xfer ? FIRST : EMPTY;
      else if (w_out_xfer)
         w_next = (r_state == FIRST && !r_cmp) ? SECOND : (w_in_xfer ? FIRST : EMPTY);
   end
   // State, word and compression flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_wd    <= '0;
         r_cmp   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_in_xfer) begin
            r_wd  <= i_in_data;
            r_cmp <= w_cmp;
         end
      end
   end
endmodule

// File: tb/tb_word_downsizer.sv
// tb_word_downsizer: scoreboard bench driving a low-first and a high-first downsizer in lockstep
module tb_word_downsizer;
   typedef struct {
      logic [15:0] d;
      logic        l;
      logic        e;
   } exp_t;
`ifdef WORD_DOWNSIZER_COMPRESS_EN
   localparam bit COMP = 1'b1;
`else
   localparam bit COMP = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        ir1, ov1, ol1, oe1, ir0, ov0, ol0, oe0;
   logic [15:0] od1, od0;
   exp_t        q1[$];
   exp_t        q0[$];
   int          total = 0;
   int          bad = 0;
   bit          rst_seen = 1'b0;
   bit          lat_pend = 1'b0;

   word_downsizer #(.LOW_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(ir1), .i_in_data(in_data),
      .o_out_valid(ov1), .i_out_ready(out_ready), .o_out_data(od1), .o_out_last(ol1), .o_out_ext(oe1));
   word_downsizer #(.LOW_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(ir0), .i_in_data(in_data),
      .o_out_valid(ov0), .i_out_ready(out_ready), .o_out_data(od0), .o_out_last(ol0), .o_out_ext(oe0));

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected half-words of one word, from the splitting rules
   task automatic push_word(input logic [31:0] w);
      if (COMP && w[31:16] == 16'h0) begin
         q1.push_back('{w[15:0], 1'b1, 1'b1});
         q0.push_back('{w[15:0], 1'b1, 1'b1});
      end else begin
         q1.push_back('{w[15:0], 1'b0, 1'b0});
         q1.push_back('{w[31:16], 1'b1, 1'b0});
         q0.push_back('{w[31:16], 1'b0, 1'b0});
         q0.push_back('{w[15:0], 1'b1, 1'b0});
      end
   endtask

   // Monitor: inputs only change just after posedge, so negedge values are what the next edge sees
   always @(negedge clk) begin
      if (rst_seen)
         chk({ov1, od1, ol1, oe1, ov0, od0, ol0, oe0} == '0, "reset_outputs",
             {ov1, ol1, oe1, od1}, 32'h0);
      if (rst) begin
         chk(ir1 == 1'b0 && ir0 == 1'b0, "in_ready_in_reset", {ir1, ir0}, 32'h0);
         q1.delete();
         q0.delete();
         lat_pend = 1'b0;
      end else begin
         if (lat_pend)
            chk(ov1 && ov0, "first_half_latency", {ov1, ov0}, 32'h3);
         chk(ov1 == ov0 && ir1 == ir0, "lockstep", {ov1, ov0, ir1, ir0}, {ov1, ov1, ir1, ir1});
         if (ov1) begin
            if (q1.size() == 0 || q0.size() == 0)
               chk(1'b0, "unexpected_output", {od1, od0}, 32'h0);
            else begin
               chk({od1, ol1, oe1} == {q1[0].d, q1[0].l, q1[0].e}, "low_first_out",
                   {od1, ol1, oe1}, {q1[0].d, q1[0].l, q1[0].e});
               chk({od0, ol0, oe0} == {q0[0].d, q0[0].l, q0[0].e}, "high_first_out",
                   {od0, ol0, oe0}, {q0[0].d, q0[0].l, q0[0].e});
               if (out_ready) begin
                  void'(q1.pop_front());
                  void'(q0.pop_front());
               end
            end
         end
         lat_pend = in_valid && ir1;
         if (lat_pend)
            push_word(in_data);
      end
      rst_seen = rst;
   end

   // Offer one word and wait (bounded) until it is taken
   task automatic put(input logic [31:0] w);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = ir1;
         @(posedge clk);
         #1;
      end
      if (!acc)
         chk(1'b0, "accept_timeout", 32'h0, 32'h1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      idle(3);
      rst = 1'b0;
      // Plain split and in_ready returning in the second cycle
      put(32'hDEADBEEF);
      @(negedge clk);
      chk(ir1 == 1'b0, "in_ready_in_first", ir1, 32'h0);
      @(negedge clk);
      chk(ir1 == 1'b1, "in_ready_in_second", ir1, 32'h1);
      idle(2);
      // Back-to-back words keep the output busy every cycle
      put(32'h11112222);
      put(32'h33334444);
      @(negedge clk);
      chk(ov1, "no_bubble_a", ov1, 32'h1);
      @(negedge clk);
      chk(ov1, "no_bubble_b", ov1, 32'h1);
      idle(2);
      // Back-pressure in FIRST holds data and blocks input
      put(32'hCAFEF00D);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(od1 == 16'hF00D && ir1 == 1'b0, "hold_under_backpressure", {ir1, od1}, 32'hF00D);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      idle(3);
      put(32'h00001234);
      idle(3);
      put(32'hA5A55A5A);
      idle(3);
      // Reset while the second half is on the bus
      put(32'h89ABCDEF);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk(ov1 == 1'b0 && od1 == 16'h0, "after_mid_reset", {ov1, od1}, 32'h0);
      put(32'h0BADF00D);
      idle(3);
      // Random traffic with random gaps, back-pressure and zero upper halves
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         acc = in_valid && ir1;
         @(posedge clk);
         #1;
         if (acc)
            in_valid = 1'b0;
         if (!in_valid && $urandom_range(2) != 0) begin
            in_valid = 1'b1;
            in_data = $urandom;
            if ($urandom_range(3) == 0)
               in_data[31:16] = 16'h0;
         end
         out_ready = ($urandom_range(3) != 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && (q1.size() != 0 || ov1); i++)
         idle(1);
      chk(q1.size() == 0 && q0.size() == 0 && !ov1, "drain", q1.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
